// File: rtl/gb_interrupt_ctrl.sv
// Interrupt controller: edge-detects the five peripheral request lines into IF,
// masks them with IE, and hands the highest-priority request to the CPU core
// through a req/ack handshake with a fixed service vector per source.
module gb_interrupt_ctrl #(
  parameter logic [15:0] VECTOR_BASE   = 16'h0040,
  parameter logic [15:0] VECTOR_STRIDE = 16'h0008
) (
  input  logic        clock,
  input  logic        nreset,
  input  logic [15:0] db_address,
  inout  wire  [7:0]  db_data,
  input  logic        nread,
  input  logic        nwrite,
  input  logic        int_vblank,
  input  logic        int_lcdstat,
  input  logic        int_timer,
  input  logic        int_serial,
  input  logic        int_joypad,
  input  logic        cpu_ime,
  input  logic        int_ack,
  output logic        int_pending,
  output logic        int_req,
  output logic [15:0] int_vector
);

  localparam logic [15:0] ADDR_IF = 16'hFF0F;
  localparam logic [15:0] ADDR_IE = 16'hFFFF;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [4:0]  src_now;
  logic [4:0]  src_prev;
  logic [4:0]  edge_set;
  logic [4:0]  if_r;
  logic [4:0]  if_next;
  logic [4:0]  masked;
  logic [7:0]  ie_r;
  logic [1:0]  state;
  logic [2:0]  sel;
  logic [15:0] vector_r;
  logic        wr_if;
  logic        wr_ie;
  logic        rd_en;
  logic [7:0]  rd_data;

  // Bit 0 has the highest priority, so the lowest set bit wins.
  function automatic logic [2:0] lowest_bit(input logic [4:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

  function automatic logic [15:0] vector_of(input logic [2:0] b);
    return VECTOR_BASE + VECTOR_STRIDE * {13'd0, b};
  endfunction

  assign src_now     = {int_joypad, int_serial, int_timer, int_lcdstat, int_vblank};
  assign edge_set    = src_now & ~src_prev;
  assign masked      = if_r & ie_r[4:0];
  assign int_pending = |masked;
  assign int_req     = (state == ST_REQ);
  assign int_vector  = vector_r;

  assign wr_if = !nwrite && (db_address == ADDR_IF);
  assign wr_ie = !nwrite && (db_address == ADDR_IE);

  // Bus read mux; the bus is released whenever we are not the read target.
  assign rd_en   = !nread && !nreset && ((db_address == ADDR_IF) || (db_address == ADDR_IE));
  assign rd_data = (db_address == ADDR_IF) ? {3'b111, if_r} : ie_r;
  assign db_data = rd_en ? rd_data : 8'hzz;

  // Next IF: bus write is overridden by the ack clear, which is overridden by a new edge.
  always_comb begin
    if_next = if_r;
    if (wr_if) if_next = db_data[4:0];
    if ((state == ST_REQ) && int_ack) if_next = if_next & ~(5'b00001 << sel);
    if_next = if_next | edge_set;
  end

  // Registers and the request handshake; sel/vector freeze once a request is issued.
  always_ff @(posedge clock) begin
    if (nreset) begin
      src_prev <= 5'd0;
      if_r     <= 5'd0;
      ie_r     <= 8'd0;
      state    <= ST_IDLE;
      sel      <= 3'd0;
      vector_r <= 16'd0;
    end else begin
      src_prev <= src_now;
      if_r     <= if_next;
      if (wr_ie) ie_r <= db_data;
      case (state)
        ST_IDLE: begin
          if (cpu_ime && int_pending) begin
            state    <= ST_REQ;
            sel      <= lowest_bit(masked);
            vector_r <= vector_of(lowest_bit(masked));
          end
        end
        ST_REQ: begin
          if (int_ack) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gb_interrupt_ctrl.sv
// Bench for gb_interrupt_ctrl: directed scenarios followed by random traffic,
// with expected bus/request behaviour queued per cycle by a reference model and
// checked by an independent monitor.
module tb_gb_interrupt_ctrl;

  logic        clock = 1'b0;
  logic        nreset;
  logic [15:0] db_address;
  wire  [7:0]  db_data;
  logic        nread;
  logic        nwrite;
  logic        int_vblank, int_lcdstat, int_timer, int_serial, int_joypad;
  logic        cpu_ime;
  logic        int_ack;
  logic        int_pending;
  logic        int_req;
  logic [15:0] int_vector;

  logic [7:0]  tb_db;
  logic        tb_db_en;
  assign db_data = tb_db_en ? tb_db : 8'hzz;

  always #5 clock = ~clock;

  gb_interrupt_ctrl dut (
    .clock       (clock),
    .nreset      (nreset),
    .db_address  (db_address),
    .db_data     (db_data),
    .nread       (nread),
    .nwrite      (nwrite),
    .int_vblank  (int_vblank),
    .int_lcdstat (int_lcdstat),
    .int_timer   (int_timer),
    .int_serial  (int_serial),
    .int_joypad  (int_joypad),
    .cpu_ime     (cpu_ime),
    .int_ack     (int_ack),
    .int_pending (int_pending),
    .int_req     (int_req),
    .int_vector  (int_vector)
  );

  typedef struct {
    int          cyc;
    logic        chk_rd;
    logic [7:0]  rd;
    logic        req;
    logic [15:0] vec;
    logic        pend;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   ncyc = 0;

  // Reference model: IF/IE contents, last source levels, and request status.
  bit [4:0]  m_if;
  bit [7:0]  m_ie;
  bit [4:0]  m_prev;
  bit        m_req;
  bit        m_cool;
  int        m_sel;
  bit [15:0] m_vec;

  bit [4:0]  s;

  // One bus cycle: drive inputs after the falling edge and queue what must be seen.
  task automatic cyc(input bit rst, input bit [4:0] src, input bit ime, input bit ack,
                     input bit rd, input bit wr, input bit [15:0] addr, input bit [7:0] data);
    exp_t     e;
    bit [4:0] msk, edges, nif;
    bit [7:0] nie;
    @(negedge clock);
    nreset = rst;
    {int_joypad, int_serial, int_timer, int_lcdstat, int_vblank} = src;
    cpu_ime    = ime;
    int_ack    = ack;
    nread      = !rd;
    nwrite     = !wr;
    db_address = addr;
    tb_db      = data;
    tb_db_en   = wr;

    e.cyc    = ncyc;
    ncyc++;
    e.chk_rd = !wr;
    e.rd     = 8'hzz;
    if (rd && !rst && !wr) begin
      if (addr == 16'hFF0F)      e.rd = {3'b111, m_if};
      else if (addr == 16'hFFFF) e.rd = m_ie;
    end

    if (rst) begin
      m_if = 0; m_ie = 0; m_prev = 0; m_req = 0; m_cool = 0; m_sel = 0; m_vec = 0;
    end else begin
      msk    = m_if & m_ie[4:0];
      edges  = src & ~m_prev;
      m_prev = src;
      nif    = m_if;
      nie    = m_ie;
      if (wr && addr == 16'hFF0F) nif = data[4:0];
      if (wr && addr == 16'hFFFF) nie = data;
      if (m_req && ack) nif[m_sel] = 1'b0;
      nif = nif | edges;
      if (m_req) begin
        if (ack) begin m_req = 0; m_cool = 1; end
      end else if (m_cool) begin
        m_cool = 0;
      end else if (ime && msk != 0) begin
        for (int b = 4; b >= 0; b--) if (msk[b]) m_sel = b;
        m_vec = 16'h0040 + 16'(m_sel * 8);
        m_req = 1;
      end
      m_if = nif;
      m_ie = nie;
    end
    e.req  = m_req;
    e.vec  = m_vec;
    e.pend = |(m_if & m_ie[4:0]);
    sb.push_back(e);
  endtask

  task automatic idle(input int n, input bit ime);
    for (int i = 0; i < n; i++) cyc(0, s, ime, 0, 0, 0, 16'h0000, 8'h00);
  endtask

  task automatic wr(input bit [15:0] a, input bit [7:0] d, input bit ime);
    cyc(0, s, ime, 0, 0, 1, a, d);
  endtask

  task automatic rd(input bit [15:0] a, input bit ime);
    cyc(0, s, ime, 0, 1, 0, a, 8'h00);
  endtask

  task automatic ack(input bit ime);
    cyc(0, s, ime, 1, 0, 0, 16'h0000, 8'h00);
  endtask

  // Monitor: bus value just before the rising edge, request outputs just after it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #4;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        if (e.chk_rd) begin
          checks++;
          if (db_data !== e.rd) begin
            errors++;
            $display("FAIL db_data cyc=%0d got=%h expected=%h", e.cyc, db_data, e.rd);
          end
        end
        @(posedge clock);
        #1;
        checks++;
        if (int_req !== e.req) begin
          errors++;
          $display("FAIL int_req cyc=%0d got=%b expected=%b", e.cyc, int_req, e.req);
        end
        checks++;
        if (int_vector !== e.vec) begin
          errors++;
          $display("FAIL int_vector cyc=%0d got=%h expected=%h", e.cyc, int_vector, e.vec);
        end
        checks++;
        if (int_pending !== e.pend) begin
          errors++;
          $display("FAIL int_pending cyc=%0d got=%b expected=%b", e.cyc, int_pending, e.pend);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout reached got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int op;
    bit r_ack, r_ime, r_rst, r_rd, r_wr;
    bit [15:0] r_addr;
    nreset = 1'b1; db_address = 0; nread = 1; nwrite = 1; cpu_ime = 0; int_ack = 0;
    {int_joypad, int_serial, int_timer, int_lcdstat, int_vblank} = 5'd0;
    tb_db = 0; tb_db_en = 0;
    s = 0;

    // Reset
    cyc(1, 0, 0, 0, 0, 0, 16'h0000, 8'h00);
    cyc(1, 0, 0, 0, 0, 0, 16'h0000, 8'h00);
    idle(1, 0);

    // Timer pulse with only timer enabled
    wr(16'hFFFF, 8'h04, 1);
    s = 5'b00100; idle(1, 1);
    s = 0;        idle(2, 1);
    rd(16'hFF0F, 1);
    ack(1);
    rd(16'hFF0F, 1);
    idle(2, 1);

    // Simultaneous vblank and joypad: vblank first, joypad after handshake
    wr(16'hFFFF, 8'h1F, 1);
    s = 5'b10001; idle(1, 1);
    s = 0;        idle(2, 1);
    ack(1);
    idle(3, 1);
    ack(1);
    idle(3, 1);

    // Master enable off: pending without request
    wr(16'hFFFF, 8'h01, 0);
    s = 5'b00001; idle(2, 0);
    rd(16'hFF0F, 0);
    idle(1, 0);
    wr(16'hFF0F, 8'h00, 0);
    rd(16'hFF0F, 0);
    s = 0; idle(1, 0);

    // Serial edge together with ack of timer request; then timer edge on ack cycle
    wr(16'hFFFF, 8'h1F, 1);
    s = 5'b00100; idle(1, 1);
    s = 0;        idle(2, 1);
    s = 5'b01000; ack(1);
    rd(16'hFF0F, 1);
    idle(2, 1);
    ack(1);
    s = 5'b00000; idle(2, 1);
    s = 5'b00100; idle(1, 1);
    s = 5'b00000; idle(2, 1);
    s = 5'b00100; ack(1);
    rd(16'hFF0F, 1);
    s = 0; idle(2, 1);
    ack(1);
    idle(2, 1);

    // Register write/read-back and edge beating a write
    wr(16'hFF0F, 8'hFF, 0);
    wr(16'hFFFF, 8'hA5, 0);
    rd(16'hFF0F, 0);
    rd(16'hFFFF, 0);
    wr(16'hFF0F, 8'h00, 0);
    s = 5'b00010;
    cyc(0, s, 0, 0, 0, 1, 16'hFF0F, 8'h00);
    rd(16'hFF0F, 0);
    s = 0;

    // Reset mid-handshake
    wr(16'hFFFF, 8'h02, 1);
    idle(3, 1);
    cyc(1, s, 1, 0, 0, 0, 16'h0000, 8'h00);
    idle(1, 1);
    rd(16'hFF0F, 1);
    rd(16'hFFFF, 1);
    rd(16'h1234, 1);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      for (int b = 0; b < 5; b++) if ($urandom_range(0, 7) == 0) s[b] = ~s[b];
      r_ime = ($urandom_range(0, 9) != 0);
      r_ack = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      r_rst = ($urandom_range(0, 149) == 0);
      op    = $urandom_range(0, 9);
      r_rd  = (op <= 2);
      r_wr  = (op == 3) || (op == 4);
      if (op == 0 || op == 3)      r_addr = 16'hFF0F;
      else if (op == 1 || op == 4) r_addr = 16'hFFFF;
      else                         r_addr = 16'($urandom_range(0, 16'hFF00));
      cyc(r_rst, s, r_ime, r_ack, r_rd, r_wr, r_addr, 8'($urandom_range(0, 255)));
    end
    idle(2, 0);

    repeat (3) @(negedge clock);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d expected=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
